// File: rtl/pipe_ctrl_if.sv
// Control bundle between the datapath and the pipeline controller.
// master = datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 5,
    parameter int PERF_W = 32
);
    logic [5:0]        d_rs;
    logic [5:0]        d_rt;
    logic [1:0]        de_rw;
    logic [4:0]        de_rd;
    logic              de_is_load;
    logic [CNT_W-1:0]  de_wait_time;
    logic              de_stop;
    logic              e_redirect;
    logic              mem_busy;
    logic              resume;
    logic [1:0]        fd_update;
    logic [1:0]        de_update;
    logic [1:0]        ew_update;
    logic              pc_we;
    logic              halted;
    logic [PERF_W-1:0] stall_count;
    logic [1:0]        dbg_state;

    modport master (
        output d_rs, d_rt, de_rw, de_rd, de_is_load, de_wait_time,
               de_stop, e_redirect, mem_busy, resume,
        input  fd_update, de_update, ew_update, pc_we, halted,
               stall_count, dbg_state
    );

    modport slave (
        input  d_rs, d_rt, de_rw, de_rd, de_is_load, de_wait_time,
               de_stop, e_redirect, mem_busy, resume,
        output fd_update, de_update, ew_update, pc_we, halted,
               stall_count, dbg_state
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-register update codes (00 hold, 01 advance,
// 10 flush) and PC enable for execute waits, load-use, redirect, memory freeze and halt.
module pipe_ctrl #(
    parameter int CNT_W  = 5,
    parameter int PERF_W = 32
) (
    input logic        clk,
    input logic        rstn,
    pipe_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_EXWAIT = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [PERF_W-1:0] stall_q;

    logic [1:0] fd_upd, de_upd, ew_upd;
    logic       pc_we, halted;
    logic       hit_rs, hit_rt, load_use;

    assign hit_rs   = (bus.de_rw[1] == bus.d_rs[5]) && (bus.de_rd == bus.d_rs[4:0]);
    assign hit_rt   = (bus.de_rw[1] == bus.d_rt[5]) && (bus.de_rd == bus.d_rt[4:0]);
    assign load_use = bus.de_is_load && (bus.de_rw != 2'b00) && (hit_rs || hit_rt);

    always_comb begin
        fd_upd  = UPD_HOLD;
        de_upd  = UPD_HOLD;
        ew_upd  = UPD_HOLD;
        pc_we   = 1'b0;
        halted  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (rstn) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mem_busy) begin
                        // whole pipe frozen, bookkeeping untouched
                    end else if ((bus.de_wait_time != '0) && !done_q) begin
                        ew_upd = UPD_FLUSH;
                        if (bus.de_wait_time == CNT_W'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = ST_EXWAIT;
                            cnt_d   = bus.de_wait_time - CNT_W'(1);
                        end
                    end else if (bus.de_stop) begin
                        fd_upd  = UPD_FLUSH;
                        de_upd  = UPD_FLUSH;
                        ew_upd  = UPD_ADV;
                        state_d = ST_HALT;
                    end else if (bus.e_redirect) begin
                        fd_upd = UPD_FLUSH;
                        de_upd = UPD_FLUSH;
                        ew_upd = UPD_ADV;
                        pc_we  = 1'b1;
                    end else if (load_use) begin
                        de_upd = UPD_FLUSH;
                        ew_upd = UPD_ADV;
                    end else begin
                        fd_upd = UPD_ADV;
                        de_upd = UPD_ADV;
                        ew_upd = UPD_ADV;
                        pc_we  = 1'b1;
                    end
                end
                ST_EXWAIT: begin
                    if (!bus.mem_busy) begin
                        ew_upd = UPD_FLUSH;
                        cnt_d  = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    ew_upd = UPD_FLUSH;
                    halted = 1'b1;
                    if (bus.resume) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
            // The waited instruction has left D/E once D/E moves at all.
            if (de_upd != UPD_HOLD) done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if ((state_q != ST_HALT) && !pc_we) stall_q <= stall_q + PERF_W'(1);
        end
    end

    assign bus.fd_update   = fd_upd;
    assign bus.de_update   = de_upd;
    assign bus.ew_update   = ew_upd;
    assign bus.pc_we       = pc_we;
    assign bus.halted      = halted;
    assign bus.stall_count = stall_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-level behavioural model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_pipe_ctrl;
    localparam int CNT_W  = 5;
    localparam int PERF_W = 32;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    logic chk_en;

    pipe_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hold_left: further hold cycles still owed by the E instruction;
    // served: its wait has been fully paid and it may now leave E.
    int              m_hold_left;
    bit              m_served;
    bit              m_halted;
    logic [PERF_W-1:0] m_stalls;

    function automatic bit m_load_use();
        bit rs_hit, rt_hit;
        rs_hit = (bus.de_rw[1] == bus.d_rs[5]) && (bus.de_rd == bus.d_rs[4:0]);
        rt_hit = (bus.de_rw[1] == bus.d_rt[5]) && (bus.de_rd == bus.d_rt[4:0]);
        return bus.de_is_load && (bus.de_rw != 2'b00) && (rs_hit || rt_hit);
    endfunction

    always @(negedge clk) begin
        logic [1:0] e_fd, e_de, e_ew;
        logic       e_pc, e_halt;
        int         n;
        if (chk_en) begin
            e_fd = 2'b00; e_de = 2'b00; e_ew = 2'b00; e_pc = 1'b0; e_halt = 1'b0;
            n = int'(bus.de_wait_time);
            if (!rstn) begin
                // everything quiet
            end else if (m_halted) begin
                e_ew = 2'b10; e_halt = 1'b1;
            end else if (bus.mem_busy) begin
                // frozen
            end else if (m_hold_left > 0) begin
                e_ew = 2'b10;
            end else if (n != 0 && !m_served) begin
                e_ew = 2'b10;
            end else if (bus.de_stop) begin
                e_fd = 2'b10; e_de = 2'b10; e_ew = 2'b01;
            end else if (bus.e_redirect) begin
                e_fd = 2'b10; e_de = 2'b10; e_ew = 2'b01; e_pc = 1'b1;
            end else if (m_load_use()) begin
                e_de = 2'b10; e_ew = 2'b01;
            end else begin
                e_fd = 2'b01; e_de = 2'b01; e_ew = 2'b01; e_pc = 1'b1;
            end

            chk("model_fd", bus.fd_update, e_fd);
            chk("model_de", bus.de_update, e_de);
            chk("model_ew", bus.ew_update, e_ew);
            chk("model_pc_we", bus.pc_we, e_pc);
            chk("model_halted", bus.halted, e_halt);
            chk("model_stalls", bus.stall_count, m_stalls);

            if (!rstn) begin
                m_hold_left = 0; m_served = 0; m_halted = 0; m_stalls = '0;
            end else begin
                if (!m_halted && !e_pc) m_stalls = m_stalls + 1;
                if (m_halted) begin
                    if (bus.resume) m_halted = 0;
                end else if (bus.mem_busy) begin
                    // nothing moves
                end else if (m_hold_left > 0) begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_served = 1;
                end else if (n != 0 && !m_served) begin
                    m_hold_left = n - 1;
                    if (n == 1) m_served = 1;
                end else begin
                    m_served = 0;
                    if (bus.de_stop) m_halted = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.d_rs = 6'h00; bus.d_rt = 6'h00; bus.de_rw = 2'b00; bus.de_rd = 5'd0;
        bus.de_is_load = 1'b0; bus.de_wait_time = '0; bus.de_stop = 1'b0;
        bus.e_redirect = 1'b0; bus.mem_busy = 1'b0; bus.resume = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] f, input logic [1:0] d,
                              input logic [1:0] e, input logic pc);
        mid();
        chk({tag, "_fd"}, bus.fd_update, f);
        chk({tag, "_de"}, bus.de_update, d);
        chk({tag, "_ew"}, bus.ew_update, e);
        chk({tag, "_pc_we"}, bus.pc_we, pc);
    endtask

    task automatic set_load_hazard();
        bus.de_is_load = 1'b1; bus.de_rw = 2'b01; bus.de_rd = 5'd5; bus.d_rs = 6'h05;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        m_hold_left = 0; m_served = 0; m_halted = 0; m_stalls = '0;
        rstn = 1'b0;
        set_idle();
        next_cycle();
        chk_en = 1'b1;
        expect_out("reset", 2'b00, 2'b00, 2'b00, 1'b0);
        next_cycle();

        rstn = 1'b1;
        next_cycle(); next_cycle();
        expect_out("idle", 2'b01, 2'b01, 2'b01, 1'b1);
        chk("idle_stalls", bus.stall_count, 0);
        next_cycle();

        rstn = 1'b0;
        expect_out("reset_pulse", 2'b00, 2'b00, 2'b00, 1'b0);
        next_cycle();
        rstn = 1'b1;

        // wait N=3: three holds then advance
        bus.de_wait_time = 5'd3;
        expect_out("wait3_c1", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle(); next_cycle();
        expect_out("wait3_c3", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle();
        expect_out("wait3_adv", 2'b01, 2'b01, 2'b01, 1'b1);
        next_cycle();
        bus.de_wait_time = '0;
        mid();
        chk("wait3_stalls", bus.stall_count, 3);
        next_cycle();

        // wait N=1: one hold
        bus.de_wait_time = 5'd1;
        expect_out("wait1_c1", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle();
        expect_out("wait1_adv", 2'b01, 2'b01, 2'b01, 1'b1);
        next_cycle();
        set_idle();

        // load-use hazards
        set_load_hazard();
        expect_out("lu_rs", 2'b00, 2'b10, 2'b01, 1'b0);
        next_cycle();
        bus.d_rs = 6'h25;
        expect_out("lu_other_file", 2'b01, 2'b01, 2'b01, 1'b1);
        next_cycle();
        bus.de_rw = 2'b10; bus.d_rt = 6'h25;
        expect_out("lu_rt", 2'b00, 2'b10, 2'b01, 1'b0);
        next_cycle();
        bus.de_rw = 2'b01; bus.de_rd = 5'd0; bus.d_rs = 6'h00; bus.d_rt = 6'h3f;
        expect_out("lu_idx0", 2'b00, 2'b10, 2'b01, 1'b0);
        next_cycle();
        bus.de_rw = 2'b00;
        expect_out("lu_nowrite", 2'b01, 2'b01, 2'b01, 1'b1);
        next_cycle();
        set_idle();
        mid();
        chk("lu_stalls", bus.stall_count, 7);
        next_cycle();

        // redirect beats load-use; with a wait it comes after the wait
        set_load_hazard(); bus.e_redirect = 1'b1;
        expect_out("redir_lu", 2'b10, 2'b10, 2'b01, 1'b1);
        next_cycle();
        bus.de_wait_time = 5'd2;
        expect_out("redir_w_c1", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle();
        expect_out("redir_w_c2", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle();
        expect_out("redir_w_go", 2'b10, 2'b10, 2'b01, 1'b1);
        next_cycle();
        set_idle();

        // halt / resume
        bus.de_stop = 1'b1;
        expect_out("stop", 2'b10, 2'b10, 2'b01, 1'b0);
        next_cycle();
        bus.de_stop = 1'b0; bus.mem_busy = 1'b1;
        expect_out("halt_busy", 2'b00, 2'b00, 2'b10, 1'b0);
        chk("halt_flag", bus.halted, 1'b1);
        next_cycle(); next_cycle();
        bus.mem_busy = 1'b0; bus.resume = 1'b1;
        mid();
        chk("halt_resume_cycle", bus.halted, 1'b1);
        next_cycle();
        bus.resume = 1'b0;
        expect_out("resumed", 2'b01, 2'b01, 2'b01, 1'b1);
        chk("resumed_flag", bus.halted, 1'b0);
        chk("halt_stalls", bus.stall_count, 10);
        next_cycle();

        // mem_busy inside EXWAIT with cnt=2
        bus.de_wait_time = 5'd3;
        next_cycle();
        bus.mem_busy = 1'b1;
        expect_out("busy_wait", 2'b00, 2'b00, 2'b00, 1'b0);
        next_cycle(); next_cycle();
        bus.mem_busy = 1'b0;
        expect_out("busy_rel_c1", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle();
        expect_out("busy_rel_c2", 2'b00, 2'b00, 2'b10, 1'b0);
        next_cycle();
        expect_out("busy_rel_adv", 2'b01, 2'b01, 2'b01, 1'b1);
        next_cycle();
        set_idle();
        bus.mem_busy = 1'b1;
        mid();
        chk("busy_stalls", bus.stall_count, 15);
        next_cycle();
        set_idle();

        // reset aborts a wait
        bus.de_wait_time = 5'd5;
        next_cycle(); next_cycle();
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1; bus.de_wait_time = '0;
        expect_out("rst_abort_wait", 2'b01, 2'b01, 2'b01, 1'b1);
        chk("rst_stalls", bus.stall_count, 0);
        next_cycle();

        // reset aborts a halt
        bus.de_stop = 1'b1;
        next_cycle();
        bus.de_stop = 1'b0;
        next_cycle();
        rstn = 1'b0;
        mid();
        chk("rst_in_halt_flag", bus.halted, 1'b0);
        next_cycle();
        rstn = 1'b1;
        expect_out("rst_abort_halt", 2'b01, 2'b01, 2'b01, 1'b1);
        next_cycle(); next_cycle();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
